// File: rtl/sram_bist_sky130_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_bist_sky130_if
// Brief    : SRAM-side port bundle between the march BIST and the SRAM wrapper.
// Revision : 1.0
// ============================================================================
interface sram_bist_sky130_if #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WMASK_WIDTH = 4
);
    logic                   sram_we;
    logic [WMASK_WIDTH-1:0] sram_wmask;
    logic [ADDR_WIDTH-1:0]  sram_addr;
    logic [DATA_WIDTH-1:0]  sram_din;
    logic [DATA_WIDTH-1:0]  sram_dout;

    modport master (
        output sram_we, sram_wmask, sram_addr, sram_din,
        input  sram_dout
    );

    modport slave (
        input  sram_we, sram_wmask, sram_addr, sram_din,
        output sram_dout
    );
endinterface
`default_nettype wire

// File: rtl/sram_bist_sky130.sv
`default_nettype none
// ============================================================================
// Module   : sram_bist_sky130
// Brief    : 4-element march BIST (W0, R0W1 up, R1W0 down, R0 up) for one
//            wrapped sky130 SRAM macro. Optional SRAM_BIST_STOP_ON_FAIL_EN
//            aborts issuing on the first mismatch.
// Revision : 1.0
// ============================================================================
module sram_bist_sky130 #(
    parameter int          ADDR_WIDTH   = 9,
    parameter int          DATA_WIDTH   = 32,
    parameter int          WMASK_WIDTH  = 4,
    parameter int          READ_LATENCY = 2,
    parameter logic [31:0] PATTERN      = 32'h5555_5555
) (
    input  wire logic              clock,
    input  wire logic              reset_n,
    input  wire logic              start,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [ADDR_WIDTH-1:0]  fail_addr,
    output logic [15:0]            fail_count,
    sram_bist_sky130_if.master     sram
);

    localparam logic [DATA_WIDTH-1:0] c_pat        = PATTERN[DATA_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] c_last       = '1;
    localparam int                    c_drain_w    = $clog2(READ_LATENCY + 1);
    localparam logic [c_drain_w-1:0]  c_drain_last = c_drain_w'(READ_LATENCY);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        W0    = 3'd1,
        R0W1  = 3'd2,
        R1W0  = 3'd3,
        R0    = 3'd4,
        DRAIN = 3'd5,
        DONE  = 3'd6
    } state_t;

    // inv selects ~PATTERN as the expected read value
    typedef struct packed {
        logic                  valid;
        logic                  inv;
        logic [ADDR_WIDTH-1:0] addr;
    } rd_t;

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_phase;
    logic [c_drain_w-1:0]   r_drain;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_fail;
    logic [ADDR_WIDTH-1:0]  r_fail_addr;
    logic [15:0]            r_fail_count;
    logic                   r_sram_we;
    logic [WMASK_WIDTH-1:0] r_sram_wmask;
    logic [ADDR_WIDTH-1:0]  r_sram_addr;
    logic [DATA_WIDTH-1:0]  r_sram_din;
    logic                   r_rd_valid;
    logic                   r_rd_inv;
    rd_t                    r_pipe [READ_LATENCY];

    rd_t                    w_tail;
    logic [DATA_WIDTH-1:0]  w_exp;
    logic                   w_mis;
    logic                   w_issuing;

    // The read on sram_addr is pushed one edge later, so the tail lines up
    // with sram_dout READ_LATENCY cycles after issue.
    assign w_tail    = r_pipe[READ_LATENCY-1];
    assign w_exp     = w_tail.inv ? ~c_pat : c_pat;
    assign w_mis     = w_tail.valid && (sram.sram_dout != w_exp);
    assign w_issuing = (r_state == W0) || (r_state == R0W1) ||
                       (r_state == R1W0) || (r_state == R0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_phase      <= 1'b0;
            r_drain      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_count <= '0;
            r_sram_we    <= 1'b0;
            r_sram_wmask <= '0;
            r_sram_addr  <= '0;
            r_sram_din   <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_inv     <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= '{valid: r_rd_valid, inv: r_rd_inv, addr: r_sram_addr};
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end

            if (w_mis) begin
                r_fail <= 1'b1;
                if (!r_fail) begin
                    r_fail_addr <= w_tail.addr;
                end
                if (r_fail_count != 16'hFFFF) begin
                    r_fail_count <= r_fail_count + 16'd1;
                end
            end

            r_sram_we    <= 1'b0;
            r_sram_wmask <= '0;
            r_rd_valid   <= 1'b0;

            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_fail       <= 1'b0;
                        r_fail_addr  <= '0;
                        r_fail_count <= '0;
                        r_done       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_addr       <= '0;
                        r_state      <= W0;
                    end
                end
                W0: begin
                    r_sram_we    <= 1'b1;
                    r_sram_wmask <= '1;
                    r_sram_addr  <= r_addr;
                    r_sram_din   <= c_pat;
                    if (r_addr == c_last) begin
                        r_addr  <= '0;
                        r_phase <= 1'b0;
                        r_state <= R0W1;
                    end else begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                end
                R0W1: begin
                    r_sram_addr <= r_addr;
                    if (!r_phase) begin
                        r_rd_valid <= 1'b1;
                        r_rd_inv   <= 1'b0;
                        r_phase    <= 1'b1;
                    end else begin
                        r_sram_we    <= 1'b1;
                        r_sram_wmask <= '1;
                        r_sram_din   <= ~c_pat;
                        r_phase      <= 1'b0;
                        if (r_addr == c_last) begin
                            r_state <= R1W0;
                        end else begin
                            r_addr <= r_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                R1W0: begin
                    r_sram_addr <= r_addr;
                    if (!r_phase) begin
                        r_rd_valid <= 1'b1;
                        r_rd_inv   <= 1'b1;
                        r_phase    <= 1'b1;
                    end else begin
                        r_sram_we    <= 1'b1;
                        r_sram_wmask <= '1;
                        r_sram_din   <= c_pat;
                        r_phase      <= 1'b0;
                        if (r_addr == '0) begin
                            r_state <= R0;
                        end else begin
                            r_addr <= r_addr - ADDR_WIDTH'(1);
                        end
                    end
                end
                R0: begin
                    r_sram_addr <= r_addr;
                    r_rd_valid  <= 1'b1;
                    r_rd_inv    <= 1'b0;
                    if (r_addr == c_last) begin
                        r_drain <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (r_drain == c_drain_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_drain <= r_drain + c_drain_w'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

`ifdef SRAM_BIST_STOP_ON_FAIL_EN
            // Abort: cancel this cycle's issue and let in-flight reads drain.
            if (w_mis && w_issuing) begin
                r_sram_we    <= 1'b0;
                r_sram_wmask <= '0;
                r_sram_addr  <= r_sram_addr;
                r_sram_din   <= r_sram_din;
                r_rd_valid   <= 1'b0;
                r_drain      <= '0;
                r_state      <= DRAIN;
            end
`else
            if (w_issuing && w_mis && r_fail_count == 16'hFFFF) begin
                r_fail <= 1'b1;
            end
`endif
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign fail            = r_fail;
    assign fail_addr       = r_fail_addr;
    assign fail_count      = r_fail_count;
    assign sram.sram_we    = r_sram_we;
    assign sram.sram_wmask = r_sram_wmask;
    assign sram.sram_addr  = r_sram_addr;
    assign sram.sram_din   = r_sram_din;

endmodule
`default_nettype wire

// File: tb/tb_sram_bist_sky130.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bist_sky130
// Brief    : Directed bench for sram_bist_sky130 with a registered SRAM model,
//            fault injection and a write-order scoreboard.
// Revision : 1.0
// ============================================================================
module tb_sram_bist_sky130;

    localparam int          AW     = 4;
    localparam int          N      = 16;
    localparam int          DW     = 32;
    localparam int          RL     = 2;
    localparam logic [31:0] PAT    = 32'h5555_5555;
    localparam int          T_DONE = 6 * N + RL + 1;
    localparam int          LIMIT  = 400;

    logic           clock   = 1'b0;
    logic           reset_n = 1'b0;
    logic           start   = 1'b0;
    logic           busy;
    logic           done;
    logic           fail;
    logic [AW-1:0]  fail_addr;
    logic [15:0]    fail_count;

    int n_tests = 0;
    int n_fail  = 0;

    // 0: healthy, 1: stuck-at-0 on one bit of one address, 2: every read inverted
    int fault_mode = 0;
    int fault_addr = 0;
    int fault_bit  = 0;

    logic [AW+DW-1:0] wr_q [$];

    sram_bist_sky130_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(4)) sif();

    sram_bist_sky130 #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .WMASK_WIDTH (4),
        .READ_LATENCY(RL),
        .PATTERN     (PAT)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_count (fail_count),
        .sram       (sif)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] fault_rd(input logic [DW-1:0] d, input int a);
        logic [DW-1:0] r;
        r = d;
        if (fault_mode == 1 && a == fault_addr) r[fault_bit] = 1'b0;
        else if (fault_mode == 2) r = ~d;
        return r;
    endfunction

    // Wrapper input register, then macro read: data valid two cycles after issue.
    logic [DW-1:0] mem [N];
    logic [AW-1:0] addr_q;
    logic [DW-1:0] dout_q;
    always @(posedge clock) begin
        if (sif.sram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sif.sram_wmask[b]) mem[sif.sram_addr][8*b +: 8] <= sif.sram_din[8*b +: 8];
            end
        end
        addr_q <= sif.sram_addr;
        dout_q <= fault_rd(mem[addr_q], int'(addr_q));
    end
    assign sif.sram_dout = dout_q;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural march over a fault-injected array: expected count and first address.
    function automatic void ref_march(output int cnt, output int first);
        logic [DW-1:0] m [N];
        cnt   = 0;
        first = -1;
        for (int a = 0; a < N; a++) m[a] = PAT;
        for (int a = 0; a < N; a++) begin
            if (fault_rd(m[a], a) !== PAT) begin cnt++; if (first < 0) first = a; end
            m[a] = ~PAT;
        end
        for (int a = N - 1; a >= 0; a--) begin
            if (fault_rd(m[a], a) !== ~PAT) begin cnt++; if (first < 0) first = a; end
            m[a] = PAT;
        end
        for (int a = 0; a < N; a++) begin
            if (fault_rd(m[a], a) !== PAT) begin cnt++; if (first < 0) first = a; end
        end
    endfunction

    task automatic push_writes();
        wr_q.delete();
        for (int a = 0; a < N; a++)      wr_q.push_back({AW'(a), PAT});
        for (int a = 0; a < N; a++)      wr_q.push_back({AW'(a), ~PAT});
        for (int a = N - 1; a >= 0; a--) wr_q.push_back({AW'(a), PAT});
    endtask

    // Called #1 after a posedge; returns edges from the start edge to done.
    task automatic run_march(input bit chk_wr, input int restart_at, output int edges);
        logic [AW+DW-1:0] got;
        logic [AW+DW-1:0] exp;
        if (chk_wr) push_writes();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_fail", fail, 0);
        check("start_fcnt", fail_count, 0);
        edges = 0;
        while (edges < LIMIT) begin
            @(posedge clock); #1;
            edges++;
            start = (edges == restart_at);
            if (chk_wr && sif.sram_we) begin
                got = {sif.sram_addr, sif.sram_din};
                exp = (wr_q.size() != 0) ? wr_q.pop_front() : ~got;
                check("write_op", {sif.sram_wmask, got}, {4'hF, exp});
            end
            if (done) break;
        end
        start = 1'b0;
        if (chk_wr) check("writes_left", wr_q.size(), 0);
    endtask

    initial begin
        int edges;
        int exp_cnt;
        int exp_first;

        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_fcnt", fail_count, 0);
        check("rst_we", sif.sram_we, 0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;

        // Fault-free run
        run_march(1'b1, -1, edges);
        check("clean_done_edge", edges, T_DONE);
        check("clean_fail", fail, 0);
        check("clean_fcnt", fail_count, 0);
        check("clean_busy", busy, 0);

`ifndef SRAM_BIST_STOP_ON_FAIL_EN
        // Bit 3 stuck-at-0 at address 5
        fault_mode = 1; fault_addr = 5; fault_bit = 3;
        ref_march(exp_cnt, exp_first);
        run_march(1'b1, -1, edges);
        check("stuck_done_edge", edges, T_DONE);
        check("stuck_fail", fail, 1);
        check("stuck_faddr", fail_addr, 5);
        check("stuck_fcnt", fail_count, exp_cnt);

        // Restart from DONE clears status; start while busy is ignored
        fault_mode = 0;
        run_march(1'b1, 20, edges);
        check("busy_start_done_edge", edges, T_DONE);
        check("restart_fail", fail, 0);
        check("restart_fcnt", fail_count, 0);

        // Every read wrong
        fault_mode = 2;
        ref_march(exp_cnt, exp_first);
        run_march(1'b1, -1, edges);
        check("inv_done_edge", edges, T_DONE);
        check("inv_fcnt", fail_count, exp_cnt);
        check("inv_faddr", fail_addr, exp_first);
        check("inv_fail", fail, 1);
        fault_mode = 0;
`else
        // Stop-on-fail with stuck bit at address 2
        begin
            int fe;
            int wr_after;
            fault_mode = 2'd0;
            fault_mode = 1; fault_addr = 2; fault_bit = 3;
            fe = -1;
            wr_after = 0;
            start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            edges = 0;
            while (edges < LIMIT) begin
                @(posedge clock); #1;
                edges++;
                if (fail && fe < 0) fe = edges;
                if (fe >= 0 && sif.sram_we) wr_after++;
                if (done) break;
            end
            check("stop_seen_fail", fe >= 0, 1);
            check("stop_no_write", wr_after, 0);
            check("stop_done_lat", (edges - fe) <= RL + 1, 1);
            check("stop_faddr", fail_addr, 2);
            fault_mode = 0;
        end
`endif

        // Asynchronous reset in the middle of R1W0
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3 * N + 6) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_fail", fail, 0);
        check("mid_rst_fcnt", fail_count, 0);
        check("mid_rst_faddr", fail_addr, 0);
        check("mid_rst_port", {sif.sram_we, sif.sram_wmask, sif.sram_addr, sif.sram_din}, 0);
        @(negedge clock) reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("post_rst_idle", {busy, done, sif.sram_we}, 0);
        run_march(1'b1, -1, edges);
        check("post_rst_done_edge", edges, T_DONE);
        check("post_rst_fail", fail, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
